// File: rtl/iob_pkg.sv
// Shared IO-bus device definitions: CONI status bit positions,
// sequencer states and small word helpers.
package iob_pkg;

    localparam int IOB_ERR  = 30;
    localparam int IOB_BUSY = 31;
    localparam int IOB_DONE = 32;
    localparam int IOB_PIA  = 33;

    localparam logic [2:0] IOB_LAST_CHAR = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } iob_state_e;

    function automatic logic [0:35] iob_status(
        input logic [2:0] pia,
        input logic       done,
        input logic       busy,
        input logic       err
    );
        logic [0:35] s;
        s = '0;
        s[IOB_ERR]      = err;
        s[IOB_BUSY]     = busy;
        s[IOB_DONE]     = done;
        s[IOB_PIA +: 3] = pia;
        return s;
    endfunction

    // Character i is word bits 6i..6i+5, bit 0 being the MSB.
    function automatic logic [0:5] iob_char(
        input logic [0:35] w,
        input logic [2:0]  i
    );
        logic [0:5] c;
        c = '0;
        case (i)
            3'd0:    c = w[0:5];
            3'd1:    c = w[6:11];
            3'd2:    c = w[12:17];
            3'd3:    c = w[18:23];
            3'd4:    c = w[24:29];
            3'd5:    c = w[30:35];
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/iob_char_punch_if.sv
// Valid/ready character link from the punch controller
// to the output device.
interface iob_char_punch_if;

    logic [0:5] chr_data;
    logic       chr_valid;
    logic       chr_ready;

    modport master (
        output chr_data,
        output chr_valid,
        input  chr_ready
    );

    modport slave (
        input  chr_data,
        input  chr_valid,
        output chr_ready
    );

endinterface

// File: rtl/iob_pia_decode.sv
// PI assignment decode: one-hot request on the channel
// held in pia while done is set; channel 0 means no request.
module iob_pia_decode (
    input  logic [2:0] pia_i,
    input  logic       done_i,
    output logic [1:7] pi_req_o
);

    always_comb begin
        pi_req_o = '0;
        for (int k = 1; k <= 7; k++) begin
            pi_req_o[k] = done_i && (pia_i == 3'(k));
        end
    end

endmodule

// File: rtl/iob_char_punch.sv
// IO-bus 6-bit character punch: CONO/CONI/DATAO/DATAI slave that
// serialises each DATAO word as six characters over a valid/ready link.
module iob_char_punch
    import iob_pkg::*;
#(
    parameter logic [6:0] DEVICE = 7'o100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iob_poweron,
    input  logic        iob_reset,
    input  logic        datao_clear,
    input  logic        datao_set,
    input  logic        cono_clear,
    input  logic        cono_set,
    input  logic        iob_fm_datai,
    input  logic        iob_fm_status,
    input  logic        rdi_pulse,
    input  logic [3:9]  ios,
    input  logic [0:35] iob_write,
    output logic [0:35] iob_read,
    output logic [1:7]  pi_req,
    output logic        dr_split,
    output logic        rdi_data,
    iob_char_punch_if.master chr
);

    logic        sel;
    logic [0:35] status;

    logic [0:35] dbuf_q, dbuf_d;
    logic [2:0]  pia_q, pia_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic [2:0]  idx_q, idx_d;
    iob_state_e  state_q, state_d;
    logic        chr_valid_q, chr_valid_d;
    logic [0:5]  chr_data_q, chr_data_d;

    logic unused_rdi;
    assign unused_rdi = rdi_pulse;

    assign sel      = (ios == DEVICE);
    assign dr_split = 1'b0;
    assign rdi_data = 1'b0;

    assign status = iob_status(pia_q, done_q, busy_q, err_q);

    assign iob_read = iob_write
                    | ({36{sel & iob_fm_datai}}  & dbuf_q)
                    | ({36{sel & iob_fm_status}} & status);

    assign chr.chr_valid = chr_valid_q;
    assign chr.chr_data  = chr_data_q;

    iob_pia_decode u_pia (
        .pia_i    (pia_q),
        .done_i   (done_q),
        .pi_req_o (pi_req)
    );

    // Later statements override earlier ones: sequencer, CONO, DATAO, clear.
    always_comb begin
        dbuf_d  = dbuf_q;
        pia_d   = pia_q;
        done_d  = done_q;
        busy_d  = busy_q;
        err_d   = err_q;
        idx_d   = idx_q;
        state_d = state_q;

        unique case (state_q)
            ST_SEND: begin
                if (chr_valid_q && chr.chr_ready) begin
                    if (idx_q == IOB_LAST_CHAR) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: ;
        endcase

        if (sel && cono_clear) begin
            pia_d  = '0;
            done_d = 1'b0;
            err_d  = 1'b0;
        end

        if (sel && cono_set) begin
            err_d  = err_d  | iob_write[IOB_ERR];
            done_d = done_d | iob_write[IOB_DONE];
            pia_d  = pia_d  | iob_write[IOB_PIA +: 3];
        end

        if (sel && (datao_clear || datao_set)) begin
            if (busy_q) begin
                err_d = 1'b1;
            end else begin
                if (datao_clear) begin
                    dbuf_d = '0;
                    done_d = 1'b0;
                end
                if (datao_set) begin
                    dbuf_d  = dbuf_d | iob_write;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    idx_d   = '0;
                    state_d = ST_SEND;
                end
            end
        end

        if (iob_reset || !iob_poweron) begin
            dbuf_d  = '0;
            pia_d   = '0;
            done_d  = 1'b0;
            busy_d  = 1'b0;
            err_d   = 1'b0;
            idx_d   = '0;
            state_d = ST_IDLE;
        end

        chr_valid_d = (state_d == ST_SEND);
        chr_data_d  = chr_valid_d ? iob_char(dbuf_d, idx_d) : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dbuf_q      <= '0;
            pia_q       <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            idx_q       <= '0;
            state_q     <= ST_IDLE;
            chr_valid_q <= 1'b0;
            chr_data_q  <= '0;
        end else begin
            dbuf_q      <= dbuf_d;
            pia_q       <= pia_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            idx_q       <= idx_d;
            state_q     <= state_d;
            chr_valid_q <= chr_valid_d;
            chr_data_q  <= chr_data_d;
        end
    end

endmodule
